// File: rtl/halt_pkg.sv
// halt_pkg: shared constants for the run/halt supervisor.
// This package holds the state encoding seen on the debug port and the default
// parameter values used by halt_monitor.
package halt_pkg;

  // FSM state encoding. These values are visible on the 'state' output, so
  // software and benches decode them directly.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RUN     = 3'd1;
  localparam logic [2:0] ST_DRAIN   = 3'd2;
  localparam logic [2:0] ST_DONE    = 3'd3;
  localparam logic [2:0] ST_TIMEOUT = 3'd4;

  typedef logic [2:0] halt_state_t;

  // Default parameter values for halt_monitor.
  localparam int unsigned DEF_CNT_W          = 32;
  localparam int unsigned DEF_DRAIN_CYCLES   = 8;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 100;
  localparam int unsigned DEF_DRAIN_W        = 8;

  // Fetch must be frozen once the stop has been accepted and in both terminal states.
  function automatic logic isHaltState(input halt_state_t s);
    return (s == ST_DRAIN) || (s == ST_DONE) || (s == ST_TIMEOUT);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up-counter that sticks at all-ones instead of wrapping.
// A clear request takes priority over an increment in the same cycle.
module sat_counter
  import halt_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         sysClk,
  input  logic         sysRst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins, otherwise step up unless already at all-ones.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge sysClk) begin
    if (sysRst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign q = count_q;

endmodule

// File: rtl/halt_monitor.sv
// halt_monitor: run/halt supervisor beside the datapath.
// Qualifies the end-of-program condition (stop with an empty call stack),
// waits a fixed pipeline-drain period before declaring done, and stops a
// runaway program with a cycle-budget watchdog. Cycle and retired-instruction
// counters cover the RUN and DRAIN phases. All outputs come from flops.
module halt_monitor
  import halt_pkg::*;
#(
  parameter int unsigned CNT_W          = DEF_CNT_W,
  parameter int unsigned DRAIN_CYCLES   = DEF_DRAIN_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned DRAIN_W        = DEF_DRAIN_W
) (
  input  logic             sysClk,
  input  logic             sysRst,
  input  logic             enable,
  input  logic             stopSignal,
  input  logic             isStackEmpty,
  input  logic             instrValid,
  output logic [2:0]       state,
  output logic             haltReq,
  output logic             done,
  output logic             timedOut,
  output logic             stopWithStack,
  output logic [CNT_W-1:0] cycleCount,
  output logic [CNT_W-1:0] instrCount
);

  // Drain count that ends the drain period (DRAIN_CYCLES must be at least 1
  // and fit in DRAIN_W bits).
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
  // Cycle count at which the watchdog fires; compared at 64 bits so a budget
  // wider than the counter can never alias onto a small count.
  localparam logic [63:0] TIMEOUT_LAST = 64'(TIMEOUT_CYCLES) - 64'd1;

  halt_state_t      state_q;
  halt_state_t      state_d;
  logic             stopWithStack_q;
  logic             stopWithStack_d;

  logic             cycleClr;
  logic             cycleInc;
  logic             instrClr;
  logic             instrInc;
  logic             drainClr;
  logic             drainInc;

  logic [CNT_W-1:0]   cycleCnt;
  logic [CNT_W-1:0]   instrCnt;
  logic [DRAIN_W-1:0] drainCnt;

  logic             stopQualified;
  logic             timeoutHit;
  logic             drainLast;
  logic [63:0]      cycleWide;

  assign stopQualified = stopSignal & isStackEmpty;
  assign cycleWide     = 64'(cycleCnt);
  assign timeoutHit    = (TIMEOUT_CYCLES != 0) && (cycleWide == TIMEOUT_LAST);
  assign drainLast     = (drainCnt == DRAIN_LAST);

  sat_counter #(.W(CNT_W)) u_cycleCounter (
    .sysClk (sysClk),
    .sysRst (sysRst),
    .clr    (cycleClr),
    .inc    (cycleInc),
    .q      (cycleCnt)
  );

  sat_counter #(.W(CNT_W)) u_instrCounter (
    .sysClk (sysClk),
    .sysRst (sysRst),
    .clr    (instrClr),
    .inc    (instrInc),
    .q      (instrCnt)
  );

  sat_counter #(.W(DRAIN_W)) u_drainCounter (
    .sysClk (sysClk),
    .sysRst (sysRst),
    .clr    (drainClr),
    .inc    (drainInc),
    .q      (drainCnt)
  );

  // Next-state and counter control. Dropping enable always wins and returns to
  // IDLE with counts held; in RUN an accepted stop beats a watchdog expiry in
  // the same cycle. Stop inputs are ignored once DRAIN has been entered.
  always_comb begin
    state_d         = state_q;
    stopWithStack_d = stopWithStack_q;
    cycleClr        = 1'b0;
    cycleInc        = 1'b0;
    instrClr        = 1'b0;
    instrInc        = 1'b0;
    drainClr        = 1'b0;
    drainInc        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d         = ST_RUN;
          cycleClr        = 1'b1;
          instrClr        = 1'b1;
          stopWithStack_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_d  = ST_IDLE;
          drainClr = 1'b1;
        end else begin
          cycleInc = 1'b1;
          instrInc = instrValid;
          if (stopSignal && !isStackEmpty) begin
            stopWithStack_d = 1'b1;
          end
          if (stopQualified) begin
            state_d  = ST_DRAIN;
            drainClr = 1'b1;
          end else if (timeoutHit) begin
            state_d = ST_TIMEOUT;
          end
        end
      end
      ST_DRAIN: begin
        if (!enable) begin
          state_d  = ST_IDLE;
          drainClr = 1'b1;
        end else begin
          cycleInc = 1'b1;
          instrInc = instrValid;
          drainInc = 1'b1;
          if (drainLast) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE, ST_TIMEOUT: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and sticky-warning registers; reset overrides everything.
  always_ff @(posedge sysClk) begin
    if (sysRst) begin
      state_q         <= ST_IDLE;
      stopWithStack_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      stopWithStack_q <= stopWithStack_d;
    end
  end

  assign state         = state_q;
  assign haltReq       = isHaltState(state_q);
  assign done          = (state_q == ST_DONE);
  assign timedOut      = (state_q == ST_TIMEOUT);
  assign stopWithStack = stopWithStack_q;
  assign cycleCount    = cycleCnt;
  assign instrCount    = instrCnt;

endmodule

// File: tb/tb_halt_monitor.sv
// tb_halt_monitor: scoreboard bench for halt_monitor.
// A driver issues whole runs (stop point, pending-return window, abort or
// reset point, random instruction pulses) and predicts each run's outcome
// from cycle arithmetic. Expected terminal results and haltReq rise times go
// into queues that a separate monitor pops whenever the DUT raises a flag.
// A second, narrow instance exercises counter saturation.
module tb_halt_monitor;
  import halt_pkg::*;

  localparam int TB_DRAIN = 8;
  localparam int TB_TMO   = 100;

  logic clock = 1'b0;
  logic reset;
  logic enable, stopSignal, isStackEmpty, instrValid;
  logic [2:0]  state;
  logic        haltReq, done, timedOut, stopWithStack;
  logic [31:0] cycleCount, instrCount;

  logic        enSat, instrSat, stopSat, emptySat;
  logic [2:0]  stateSat;
  logic        haltSat, doneSat, toSat, swwSat;
  logic [3:0]  cycSat, insSat;

  int     nChecks = 0;
  int     nFails  = 0;
  longint tbCycle = 0;

  typedef struct {
    bit     isTimeout;
    longint cyc;
    longint ins;
    bit     sww;
    longint when;
  } endRec_t;

  endRec_t endQ[$];
  longint  haltQ[$];
  endRec_t rec;
  longint  haltWhen;
  bit      prevEnd  = 1'b0;
  bit      prevHalt = 1'b0;

  halt_monitor #(
    .CNT_W(32), .DRAIN_CYCLES(TB_DRAIN), .TIMEOUT_CYCLES(TB_TMO), .DRAIN_W(8)
  ) dut (
    .sysClk(clock), .sysRst(reset), .enable(enable), .stopSignal(stopSignal),
    .isStackEmpty(isStackEmpty), .instrValid(instrValid), .state(state),
    .haltReq(haltReq), .done(done), .timedOut(timedOut),
    .stopWithStack(stopWithStack), .cycleCount(cycleCount), .instrCount(instrCount)
  );

  halt_monitor #(
    .CNT_W(4), .DRAIN_CYCLES(2), .TIMEOUT_CYCLES(0), .DRAIN_W(4)
  ) dutSat (
    .sysClk(clock), .sysRst(reset), .enable(enSat), .stopSignal(stopSat),
    .isStackEmpty(emptySat), .instrValid(instrSat), .state(stateSat),
    .haltReq(haltSat), .done(doneSat), .timedOut(toSat),
    .stopWithStack(swwSat), .cycleCount(cycSat), .instrCount(insSat)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // Edge counter used to timestamp expected flag rises.
  always @(posedge clock) tbCycle <= tbCycle + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkIdle(input string tag, input longint cyc, input longint ins, input bit sww);
    checkOutput({tag, "_state"}, 64'(state), 64'(ST_IDLE));
    checkOutput({tag, "_haltReq"}, 64'(haltReq), 0);
    checkOutput({tag, "_done"}, 64'(done), 0);
    checkOutput({tag, "_timedOut"}, 64'(timedOut), 0);
    checkOutput({tag, "_cycleCount"}, 64'(cycleCount), 64'(cyc));
    checkOutput({tag, "_instrCount"}, 64'(instrCount), 64'(ins));
    checkOutput({tag, "_stopWithStack"}, 64'(stopWithStack), 64'(sww));
  endtask

  // One run from IDLE. stopAt is the RUN cycle (counter value) at which a
  // clean stop is presented; values >= TB_TMO mean the watchdog ends the run.
  // pendLen cycles of stop-with-stack precede the stop. abortAt/rstAt (>=0)
  // drop enable or pulse reset in that cycle instead of finishing.
  task automatic applyStimulus(input int stopAt, input int pendLen, input bit noise,
                               input bit fixedPulses, input int abortAt, input int rstAt);
    int     lastRun, total, instrExp, endK, abortIdx;
    bit     swwExp, toPath, en, s, e, iv;
    longint t0;
    endRec_t r;
    toPath = (stopAt >= TB_TMO);
    if (toPath) begin
      lastRun = TB_TMO - 1;
      total   = TB_TMO;
    end else begin
      lastRun = stopAt;
      total   = stopAt + 1 + TB_DRAIN;
    end
    abortIdx = abortAt;
    instrExp = 0;
    swwExp   = 1'b0;
    stopSignal = 1'b0; isStackEmpty = 1'b0; instrValid = 1'b0;
    enable = 1'b1;
    tick();
    t0 = tbCycle;
    if ((abortAt < 0 && rstAt < 0) || (abortAt > lastRun) || (rstAt > lastRun)) begin
      haltQ.push_back(t0 + (toPath ? TB_TMO : stopAt + 1));
    end
    if (abortAt >= 0)    endK = abortAt;
    else if (rstAt >= 0) endK = rstAt;
    else                 endK = total + 2;
    for (int k = 0; k <= endK; k++) begin
      en = !(abortAt >= 0 && k >= abortAt);
      enable = en;
      reset  = (rstAt >= 0 && k == rstAt);
      if (k < stopAt) begin
        if (k >= stopAt - pendLen) begin
          s = 1'b1; e = 1'b0;
        end else if (noise) begin
          s = ($urandom_range(0, 4) == 0);
          e = s ? 1'b0 : ($urandom_range(0, 1) == 1);
        end else begin
          s = 1'b0; e = 1'b0;
        end
      end else if (k == stopAt) begin
        s = 1'b1; e = 1'b1;
      end else begin
        s = ($urandom_range(0, 1) == 1);
        e = ($urandom_range(0, 1) == 1);
      end
      iv = fixedPulses ? (k < 10 && (k % 2) == 1) : ($urandom_range(0, 1) == 1);
      stopSignal = s; isStackEmpty = e; instrValid = iv;
      if (en && k < total) instrExp += int'(iv);
      if (en && k <= lastRun && s && !e) swwExp = 1'b1;
      if (abortAt < 0 && rstAt < 0 && k == total - 1) begin
        r.isTimeout = toPath;
        r.cyc  = total;
        r.ins  = instrExp;
        r.sww  = swwExp;
        r.when = t0 + total;
        endQ.push_back(r);
      end
      tick();
    end
    stopSignal = 1'b0; isStackEmpty = 1'b0; instrValid = 1'b0;
    if (rstAt >= 0) begin
      reset = 1'b0; enable = 1'b0;
      checkIdle("resetMidDrain", 0, 0, 1'b0);
    end else if (abortIdx >= 0) begin
      checkIdle("abort", abortIdx, instrExp, swwExp);
      total = abortIdx;
    end else begin
      enable = 1'b0;
      tick();
      checkIdle("endToIdle", total, instrExp, swwExp);
    end
    repeat ($urandom_range(1, 3)) tick();
    checkOutput("idleHoldCycles", 64'(cycleCount), (rstAt >= 0) ? 0 : 64'(total));
  endtask

  // Monitor: pops an expected record whenever a terminal flag or haltReq rises.
  initial begin
    forever begin
      @(negedge clock);
      if (((done === 1'b1) || (timedOut === 1'b1)) && !prevEnd) begin
        if (endQ.size() == 0) begin
          nChecks++; nFails++;
          $display("[TB] FAIL unexpectedEnd: got done=%0d timedOut=%0d, expected no terminal flag", done, timedOut);
        end else begin
          rec = endQ.pop_front();
          checkOutput("endDone", 64'(done), 64'(!rec.isTimeout));
          checkOutput("endTimedOut", 64'(timedOut), 64'(rec.isTimeout));
          checkOutput("endTime", 64'(tbCycle), 64'(rec.when));
          checkOutput("endCycleCount", 64'(cycleCount), 64'(rec.cyc));
          checkOutput("endInstrCount", 64'(instrCount), 64'(rec.ins));
          checkOutput("endStopWithStack", 64'(stopWithStack), 64'(rec.sww));
          checkOutput("endHaltReq", 64'(haltReq), 1);
        end
      end
      if ((haltReq === 1'b1) && !prevHalt) begin
        if (haltQ.size() == 0) begin
          nChecks++; nFails++;
          $display("[TB] FAIL unexpectedHaltReq: got rise at cycle %0d, expected none", tbCycle);
        end else begin
          haltWhen = haltQ.pop_front();
          checkOutput("haltReqRiseTime", 64'(tbCycle), 64'(haltWhen));
        end
      end
      prevEnd  = (done === 1'b1) || (timedOut === 1'b1);
      prevHalt = (haltReq === 1'b1);
    end
  end

  // Main sequence: reset, directed scenarios, random runs, saturation.
  initial begin
    int stopAt, total, abortAt;
    reset = 1'b1; enable = 1'b0; stopSignal = 1'b0; isStackEmpty = 1'b0; instrValid = 1'b0;
    enSat = 1'b0; instrSat = 1'b0; stopSat = 1'b0; emptySat = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    checkIdle("reset", 0, 0, 1'b0);
    $display("[TB] directed scenarios");
    applyStimulus(20, 0, 1'b0, 1'b1, -1, -1);
    applyStimulus(1000, 0, 1'b0, 1'b0, -1, -1);
    applyStimulus(99, 0, 1'b0, 1'b0, -1, -1);
    applyStimulus(10, 3, 1'b0, 1'b0, -1, -1);
    applyStimulus(12, 0, 1'b0, 1'b0, -1, 16);
    applyStimulus(0, 0, 1'b0, 1'b0, -1, -1);
    applyStimulus(50, 0, 1'b1, 1'b0, 15, -1);
    applyStimulus(10, 0, 1'b1, 1'b0, 14, -1);
    $display("[TB] random runs");
    for (int n = 0; n < 14; n++) begin
      stopAt  = $urandom_range(0, 130);
      total   = (stopAt >= TB_TMO) ? TB_TMO : stopAt + 1 + TB_DRAIN;
      abortAt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, total - 1) : -1;
      applyStimulus(stopAt, $urandom_range(0, 3), 1'b1, 1'b0, abortAt, -1);
    end
    $display("[TB] saturation instance");
    enSat = 1'b1; instrSat = 1'b1;
    tick();
    repeat (20) tick();
    checkOutput("satState", 64'(stateSat), 64'(ST_RUN));
    checkOutput("satCycle20", 64'(cycSat), 15);
    checkOutput("satInstr20", 64'(insSat), 15);
    repeat (5) tick();
    checkOutput("satCycleHeld", 64'(cycSat), 15);
    checkOutput("satNoWatchdog", 64'(toSat), 0);
    enSat = 1'b0;
    tick();
    checkOutput("satAbortState", 64'(stateSat), 64'(ST_IDLE));
    checkOutput("satAbortCycle", 64'(cycSat), 15);
    checkOutput("satAbortInstr", 64'(insSat), 15);
    tick();
    checkOutput("satIdleHold", 64'(cycSat), 15);
    enSat = 1'b1; instrSat = 1'b0;
    tick();
    checkOutput("satReenState", 64'(stateSat), 64'(ST_RUN));
    checkOutput("satReenCycle", 64'(cycSat), 0);
    checkOutput("satReenInstr", 64'(insSat), 0);
    enSat = 1'b0;
    repeat (3) tick();
    while (endQ.size() != 0) begin
      rec = endQ.pop_front();
      nChecks++; nFails++;
      $display("[TB] FAIL missingEnd: got no terminal flag, expected one at cycle %0d", rec.when);
    end
    while (haltQ.size() != 0) begin
      haltWhen = haltQ.pop_front();
      nChecks++; nFails++;
      $display("[TB] FAIL missingHaltReq: got no rise, expected one at cycle %0d", haltWhen);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
